// File: rtl/req_assembler_if.sv
// rtl/req_assembler_if.sv - byte-in / frame-out bundle between UART RX, req_assembler and the dispatcher
//
// Signals:
//   rx_byte      [7:0]  byte from the UART RX buffer, valid with rx_done
//   rx_done             one-cycle strobe, new byte available
//   sensor_busy         high while any sensor module is serving a request
//   cmd_out      [7:0]  command byte of the last delivered frame
//   addr_out     [4:0]  sensor address of the last delivered frame
//   req_ready           one-cycle strobe, frame delivered
//   frame_err           one-cycle strobe, frame discarded
//   overrun             one-cycle strobe, byte dropped while a frame was pending
//
// Modports:
//   master - the byte source / frame consumer side (drives rx_byte, rx_done, sensor_busy)
//   slave  - the assembler itself

interface req_assembler_if;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       sensor_busy;
    logic [7:0] cmd_out;
    logic [4:0] addr_out;
    logic       req_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_byte,
        output rx_done,
        output sensor_busy,
        input  cmd_out,
        input  addr_out,
        input  req_ready,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  rx_byte,
        input  rx_done,
        input  sensor_busy,
        output cmd_out,
        output addr_out,
        output req_ready,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/req_assembler.sv
// rtl/req_assembler.sv - two-byte request frame assembler (command byte, then address byte)
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles between command and address byte (>= 2)
//   MAX_ADDR        highest populated sensor address (used only with ADDR_CHECK_EN)
//
// Optional feature macro:
//   ADDR_CHECK_EN   when defined, address bytes with rx_byte[7:5] != 0 or
//                   rx_byte[4:0] > MAX_ADDR are rejected with frame_err
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    req_assembler_if.slave (rx_byte/rx_done/sensor_busy in,
//          cmd_out/addr_out/req_ready/frame_err/overrun out)

module req_assembler #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int MAX_ADDR       = 8
) (
    input  logic           clk,
    input  logic           reset,
    req_assembler_if.slave bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ADDR = 2'd1;
    localparam logic [1:0] ST_PENDING   = 2'd2;

    logic [1:0]       state;
    logic [7:0]       cmd_q;
    logic [4:0]       addr_q;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       cmd_out_q;
    logic [4:0]       addr_out_q;
    logic             req_ready_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             addr_ok;

`ifdef ADDR_CHECK_EN
    logic [31:0] addr_wide;

    always_comb begin
        addr_wide = {27'd0, bus.rx_byte[4:0]};
        addr_ok   = (bus.rx_byte[7:5] == 3'd0) && (addr_wide <= $unsigned(MAX_ADDR));
    end
`else
    // Without the check any 5-bit address is deliverable; MAX_ADDR has no role.
    localparam int unused_max_addr = MAX_ADDR;

    always_comb begin
        addr_ok = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            cnt         <= '0;
            cmd_out_q   <= '0;
            addr_out_q  <= '0;
            req_ready_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            req_ready_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.rx_done) begin
                        cmd_q <= bus.rx_byte;
                        cnt   <= '0;
                        state <= ST_WAIT_ADDR;
                    end
                end

                ST_WAIT_ADDR: begin
                    // A byte arriving on the timeout cycle itself wins over the timeout.
                    if (bus.rx_done) begin
                        if (addr_ok) begin
                            addr_q <= bus.rx_byte[4:0];
                            state  <= ST_PENDING;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        frame_err_q <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_PENDING: begin
                    // An overrun cycle defers delivery by one cycle so the three
                    // strobes never coincide.
                    if (bus.rx_done) begin
                        overrun_q <= 1'b1;
                    end else if (!bus.sensor_busy) begin
                        cmd_out_q   <= cmd_q;
                        addr_out_q  <= addr_q;
                        req_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_out   = cmd_out_q;
    assign bus.addr_out  = addr_out_q;
    assign bus.req_ready = req_ready_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_req_assembler.sv
// tb/tb_req_assembler.sv - self-checking bench for req_assembler (TIMEOUT_CYCLES=16, MAX_ADDR=8)

module tb_req_assembler;

    localparam int T    = 16;
    localparam int MAXA = 8;

    logic clk;
    logic reset;

    req_assembler_if bus ();

    req_assembler #(
        .TIMEOUT_CYCLES(T),
        .MAX_ADDR(MAXA)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_ready, n_err, n_ovr, n_multi;
    int ready_cyc, err_cyc;
    logic [7:0] exp_cmd;
    logic [4:0] exp_addr;

`ifdef ADDR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    function automatic bit addr_valid(input logic [7:0] b);
        if (!CHECK) return 1'b1;
        return (b[7:5] == 3'd0) && (int'(b[4:0]) <= MAXA);
    endfunction

    task automatic clear_counts();
        n_ready = 0; n_err = 0; n_ovr = 0; n_multi = 0;
        ready_cyc = -1; err_cyc = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.req_ready) begin n_ready++; ready_cyc = cyc; end
        if (bus.frame_err) begin n_err++; err_cyc = cyc; end
        if (bus.overrun) n_ovr++;
        if (int'(bus.req_ready) + int'(bus.frame_err) + int'(bus.overrun) > 1) n_multi++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte = b;
        bus.rx_done = 1'b1;
        step();
        bus.rx_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rx_done = 1'b0;
        bus.rx_byte = 8'h00;
        bus.sensor_busy = 1'b0;
        repeat (3) step();
        n_tests++; if (bus.cmd_out !== 8'h00) begin n_fail++; $display("FAIL reset_cmd: got %h want 00", bus.cmd_out); end
        n_tests++; if (bus.addr_out !== 5'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", bus.addr_out); end
        n_tests++; if ({bus.req_ready, bus.frame_err, bus.overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {bus.req_ready, bus.frame_err, bus.overrun}); end
        reset = 1'b0;
        exp_cmd = 8'h00; exp_addr = 5'h00;
    endtask

    task automatic test_basic();
        clear_counts();
        send_byte(8'h03);
        send_byte(8'h05);
        n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL basic_early: req_ready got %b want 0", bus.req_ready); end
        step();
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", bus.req_ready); end
        n_tests++; if (bus.cmd_out !== 8'h03) begin n_fail++; $display("FAIL basic_cmd: got %h want 03", bus.cmd_out); end
        n_tests++; if (bus.addr_out !== 5'd5) begin n_fail++; $display("FAIL basic_addr: got %0d want 5", bus.addr_out); end
        step();
        n_tests++; if (n_ready !== 1) begin n_fail++; $display("FAIL basic_width: ready count %0d want 1", n_ready); end
        exp_cmd = 8'h03; exp_addr = 5'd5;
    endtask

    task automatic test_timeout();
        int c0;
        clear_counts();
        send_byte(8'h01);
        c0 = cyc;
        repeat (T + 2) step();
        n_tests++; if (n_err !== 1 || err_cyc !== c0 + T) begin n_fail++; $display("FAIL timeout_err: count %0d at %0d want 1 at %0d", n_err, err_cyc, c0 + T); end
        n_tests++; if (n_ready !== 0) begin n_fail++; $display("FAIL timeout_noready: got %0d want 0", n_ready); end
        clear_counts();
        send_byte(8'h02);
        send_byte(8'h01);
        step();
        n_tests++; if (bus.req_ready !== 1'b1 || bus.cmd_out !== 8'h02 || bus.addr_out !== 5'd1) begin n_fail++; $display("FAIL timeout_recover: ready %b cmd %h addr %0d want 1 02 1", bus.req_ready, bus.cmd_out, bus.addr_out); end
        exp_cmd = 8'h02; exp_addr = 5'd1;
    endtask

    task automatic test_timeout_boundary();
        clear_counts();
        send_byte(8'h07);
        repeat (T - 1) step();
        send_byte(8'h06);
        step();
        step();
        n_tests++; if (n_err !== 0) begin n_fail++; $display("FAIL boundary_err: got %0d want 0", n_err); end
        n_tests++; if (n_ready !== 1 || bus.cmd_out !== 8'h07 || bus.addr_out !== 5'd6) begin n_fail++; $display("FAIL boundary_deliver: ready %0d cmd %h addr %0d want 1 07 6", n_ready, bus.cmd_out, bus.addr_out); end
        exp_cmd = 8'h07; exp_addr = 5'd6;
    endtask

    task automatic test_busy_overrun();
        clear_counts();
        bus.sensor_busy = 1'b1;
        send_byte(8'h04);
        send_byte(8'h02);
        repeat (4) step();
        send_byte(8'h55);
        n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_strobe: got %b want 1", bus.overrun); end
        n_tests++; if (bus.cmd_out !== exp_cmd || bus.addr_out !== exp_addr) begin n_fail++; $display("FAIL overrun_hold: cmd %h addr %0d want %h %0d", bus.cmd_out, bus.addr_out, exp_cmd, exp_addr); end
        repeat (5) step();
        n_tests++; if (n_ready !== 0) begin n_fail++; $display("FAIL busy_hold: ready count %0d want 0", n_ready); end
        bus.sensor_busy = 1'b0;
        step();
        n_tests++; if (bus.req_ready !== 1'b1 || bus.cmd_out !== 8'h04 || bus.addr_out !== 5'd2) begin n_fail++; $display("FAIL busy_release: ready %b cmd %h addr %0d want 1 04 2", bus.req_ready, bus.cmd_out, bus.addr_out); end
        step();
        n_tests++; if (n_ovr !== 1 || n_ready !== 1 || n_multi !== 0) begin n_fail++; $display("FAIL busy_counts: ovr %0d ready %0d multi %0d want 1 1 0", n_ovr, n_ready, n_multi); end
        exp_cmd = 8'h04; exp_addr = 5'd2;
    endtask

    task automatic test_addr_check();
        logic [7:0] abytes [2];
        abytes[0] = 8'h09;
        abytes[1] = 8'h21;
        for (int i = 0; i < 2; i++) begin
            clear_counts();
            send_byte(8'h01);
            send_byte(abytes[i]);
            step();
            step();
            if (CHECK) begin
                n_tests++; if (n_err !== 1 || n_ready !== 0) begin n_fail++; $display("FAIL addr_reject_%0d: err %0d ready %0d want 1 0", i, n_err, n_ready); end
                n_tests++; if (bus.cmd_out !== exp_cmd || bus.addr_out !== exp_addr) begin n_fail++; $display("FAIL addr_reject_hold_%0d: cmd %h addr %0d want %h %0d", i, bus.cmd_out, bus.addr_out, exp_cmd, exp_addr); end
            end else begin
                exp_cmd = 8'h01; exp_addr = abytes[i][4:0];
                n_tests++; if (n_err !== 0 || n_ready !== 1) begin n_fail++; $display("FAIL addr_accept_%0d: err %0d ready %0d want 0 1", i, n_err, n_ready); end
                n_tests++; if (bus.cmd_out !== exp_cmd || bus.addr_out !== exp_addr) begin n_fail++; $display("FAIL addr_accept_val_%0d: cmd %h addr %0d want %h %0d", i, bus.cmd_out, bus.addr_out, exp_cmd, exp_addr); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_counts();
        send_byte(8'h0A);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++; if (bus.cmd_out !== 8'h00 || bus.addr_out !== 5'd0) begin n_fail++; $display("FAIL midreset_outs: cmd %h addr %0d want 00 0", bus.cmd_out, bus.addr_out); end
        n_tests++; if (n_ready + n_err + n_ovr !== 0) begin n_fail++; $display("FAIL midreset_strobes: got %0d want 0", n_ready + n_err + n_ovr); end
        send_byte(8'h03);
        send_byte(8'h04);
        step();
        n_tests++; if (bus.req_ready !== 1'b1 || bus.cmd_out !== 8'h03 || bus.addr_out !== 5'd4) begin n_fail++; $display("FAIL midreset_next: ready %b cmd %h addr %0d want 1 03 4", bus.req_ready, bus.cmd_out, bus.addr_out); end
        exp_cmd = 8'h03; exp_addr = 5'd4;
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_byte(8'hA1);
        send_byte(8'h07);
        step();
        send_byte(8'hB2);
        send_byte(8'h03);
        step();
        n_tests++; if (n_ready !== 2 || bus.cmd_out !== 8'hB2 || bus.addr_out !== 5'd3) begin n_fail++; $display("FAIL back_to_back: ready %0d cmd %h addr %0d want 2 b2 3", n_ready, bus.cmd_out, bus.addr_out); end
        exp_cmd = 8'hB2; exp_addr = 5'd3;
    endtask

    task automatic test_random();
        int g, b, c0, a0;
        logic [7:0] cb, ab;
        for (int f = 0; f < 40; f++) begin
            clear_counts();
            cb = 8'($urandom);
            ab = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, MAXA)) : 8'($urandom);
            g  = $urandom_range(1, T + 3);
            b  = $urandom_range(0, 6);
            send_byte(cb);
            c0 = cyc;
            if (g > T) begin
                repeat (T + 2) step();
                n_tests++; if (n_err !== 1 || err_cyc !== c0 + T || n_ready !== 0) begin n_fail++; $display("FAIL rand_timeout_%0d: err %0d at %0d ready %0d want 1 at %0d 0", f, n_err, err_cyc, n_ready, c0 + T); end
            end else begin
                repeat (g - 1) step();
                send_byte(ab);
                a0 = cyc;
                if (!addr_valid(ab)) begin
                    repeat (2) step();
                    n_tests++; if (n_err !== 1 || err_cyc !== a0 || n_ready !== 0) begin n_fail++; $display("FAIL rand_reject_%0d: err %0d at %0d ready %0d want 1 at %0d 0", f, n_err, err_cyc, n_ready, a0); end
                end else begin
                    bus.sensor_busy = (b > 0);
                    repeat (b) step();
                    bus.sensor_busy = 1'b0;
                    repeat (3) step();
                    exp_cmd = cb; exp_addr = ab[4:0];
                    n_tests++; if (n_ready !== 1 || ready_cyc !== a0 + b + 1 || n_err !== 0) begin n_fail++; $display("FAIL rand_deliver_%0d: ready %0d at %0d err %0d want 1 at %0d 0", f, n_ready, ready_cyc, n_err, a0 + b + 1); end
                end
            end
            n_tests++; if (bus.cmd_out !== exp_cmd || bus.addr_out !== exp_addr) begin n_fail++; $display("FAIL rand_outs_%0d: cmd %h addr %0d want %h %0d", f, bus.cmd_out, bus.addr_out, exp_cmd, exp_addr); end
            n_tests++; if (n_ovr !== 0 || n_multi !== 0) begin n_fail++; $display("FAIL rand_strobes_%0d: ovr %0d multi %0d want 0 0", f, n_ovr, n_multi); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_timeout_boundary();
        test_busy_overrun();
        test_addr_check();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
